dsc_sn2bin: RTL

Deterministic stochastic-to-binary converter. It sits directly downstream of the counter-based DSC stochastic number generator and drives that generator's enable. For one full deterministic window it counts the ones on the incoming stochastic bitstream, scales the count back into binary units, and presents the result on a valid/ready output handshake.

---
 rtl/dsc_sn2bin_pkg.sv | 24 ++
 rtl/dsc_sn2bin_if.sv | 32 +++
 rtl/dsc_window_ctr.sv | 42 ++++
 rtl/dsc_sn2bin.sv | 105 ++++++++++
 4 files changed

// File: rtl/dsc_sn2bin_pkg.sv
// Shared definitions for the stochastic-to-binary converter.
//   clog2()  : elaboration-time ceiling log2, also used by the upstream SNG.
//   state_e  : 2-bit converter state encoding (idle / run / done).
package dsc_sn2bin_pkg;

  // Ceiling log2; clog2(1) == 0. Loop bound is fixed so it stays synthesizable.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/dsc_sn2bin_if.sv
// Handshake bundle between the converter, its upstream SNG and its consumer.
//   start     : one-cycle convert request
//   sn_in     : stochastic bit from the SNG
//   sng_en    : SNG counter enable (high during RUN)
//   busy      : converter in RUN or DONE
//   out_valid : result available
//   out_ready : consumer accepts result
//   result    : scaled ones count, Width+1 bits
// master = requester/consumer side, slave = converter side.
interface dsc_sn2bin_if #(
  parameter int unsigned Width = 4
) ();

  logic             start;
  logic             sn_in;
  logic             sng_en;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [Width:0]   result;

  modport master (
    output start, sn_in, out_ready,
    input  sng_en, busy, out_valid, result
  );

  modport slave (
    input  start, sn_in, out_ready,
    output sng_en, busy, out_valid, result
  );

endinterface

// File: rtl/dsc_window_ctr.sv
// Window counter for the stochastic-to-binary converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over enable)
//   en_i       : advance by one
//   last_o     : count equals N-1 (last sampled cycle of the window)
module dsc_window_ctr
  import dsc_sn2bin_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned CntW = (clog2(N) < 1) ? 1 : clog2(N);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // Explicit wrap keeps the window aligned even if N were not a power of two.
      cnt_d = last_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CntW'(N - 1));

endmodule

// File: rtl/dsc_sn2bin.sv
// Deterministic stochastic-to-binary converter.
// Counts ones on sn_in over one full wrap of the upstream SNG counter
// (N = 2^Width / Stride cycles), scales by Stride and offers the result
// on a valid/ready handshake. Drives the SNG enable so the upstream
// counter only moves while a window is being sampled.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of dsc_sn2bin_if (start, sn_in, sng_en, busy,
//                out_valid, out_ready, result)
module dsc_sn2bin
  import dsc_sn2bin_pkg::*;
#(
  parameter int unsigned Width  = 4,
  parameter int unsigned Stride = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dsc_sn2bin_if.slave bus
);

  localparam int unsigned N      = (1 << Width) / Stride;
  localparam int unsigned CntW   = clog2(N);
  localparam int unsigned AccW   = CntW + 1;  // holds N without wrapping
  localparam int unsigned ShiftW = clog2(Stride);
  localparam int unsigned ResW   = Width + 1;

  state_e            state_q, state_d;
  logic [AccW-1:0]   acc_q, acc_d, acc_sum;
  logic [ResW-1:0]   result_q, result_d;
  logic              win_clr, win_en, win_last;

  dsc_window_ctr #(
    .N (N)
  ) u_window_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (win_clr),
    .en_i   (win_en),
    .last_o (win_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is only looked at in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StRun;
      StRun:  if (win_last) state_d = StDone;
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from the state flop so reset clears them at once.
  always_comb begin
    bus.sng_en    = (state_q == StRun);
    bus.busy      = (state_q != StIdle);
    bus.out_valid = (state_q == StDone);
    bus.result    = result_q;
  end

  // Accumulator and result register.
  always_comb begin
    acc_sum  = acc_q + AccW'(bus.sn_in);
    acc_d    = acc_q;
    result_d = result_q;
    win_clr  = 1'b0;
    win_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = '0;
          win_clr = 1'b1;
        end
      end
      StRun: begin
        acc_d  = acc_sum;
        win_en = 1'b1;
        // Capture includes the bit sampled in the last window cycle.
        if (win_last) begin
          result_d = ResW'(acc_sum) << ShiftW;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule
